// File: rtl/picoMIPS_pkg.sv
// Shared types and constants for the picoMIPS switch/button input conditioning.
package picoMIPS_pkg;

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    PRS       = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_t;

  localparam logic [15:0] DEB_CYCLES_DEFAULT = 16'd50000;

endpackage

// File: rtl/switch_conditioner_sync2.sv
// sync2: parameterised-width two-flop synchronizer with asynchronous active-low clear.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions the slide-switch bank and push-button for the picoMIPS CPU.
// Optional macro SW_DEBOUNCE_EN adds a whole-bus stability filter on x.
module switch_conditioner
  import picoMIPS_pkg::*;
#(
  parameter int          n          = 8,
  parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [n-1:0] sw,
  input  logic         btn,
  output logic [n-1:0] x,
  output logic         Bstus,
  output logic         Bpulse
);

  localparam int            CW       = $clog2(int'(DEB_CYCLES) + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(int'(DEB_CYCLES) - 1);

  logic [n-1:0] sw_sync;
  logic [0:0]   btn_sync;

  sync2 #(.W(n)) u_sync_sw (
    .clk    (clk),
    .nreset (nreset),
    .d      (sw),
    .q      (sw_sync)
  );

  sync2 #(.W(1)) u_sync_btn (
    .clk    (clk),
    .nreset (nreset),
    .d      (btn),
    .q      (btn_sync)
  );

  btn_state_t    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          bstus_reg;
  logic          bpulse_reg;

  // Outputs are updated together with the state so Bstus/Bpulse change on the same edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg  <= REL;
      cnt_reg    <= '0;
      bstus_reg  <= 1'b0;
      bpulse_reg <= 1'b0;
    end else begin
      bpulse_reg <= 1'b0;
      case (state_reg)
        REL: begin
          if (btn_sync[0]) begin
            state_reg <= PRESS_CHK;
            cnt_reg   <= CNT_ONE;
          end
        end
        PRESS_CHK: begin
          if (!btn_sync[0]) begin
            state_reg <= REL;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg  <= PRS;
            cnt_reg    <= '0;
            bstus_reg  <= 1'b1;
            bpulse_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        PRS: begin
          if (!btn_sync[0]) begin
            state_reg <= REL_CHK;
            cnt_reg   <= CNT_ONE;
          end
        end
        REL_CHK: begin
          if (btn_sync[0]) begin
            state_reg <= PRS;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= REL;
            cnt_reg   <= '0;
            bstus_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg <= REL;
          cnt_reg   <= '0;
          bstus_reg <= 1'b0;
        end
      endcase
    end
  end

  assign Bstus  = bstus_reg;
  assign Bpulse = bpulse_reg;

`ifdef SW_DEBOUNCE_EN
  logic [n-1:0]  sw_last_reg;
  logic [n-1:0]  x_reg;
  logic [CW-1:0] sw_cnt_reg;

  // One shared counter for the whole bus; any bit change restarts it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sw_last_reg <= '0;
      x_reg       <= '0;
      sw_cnt_reg  <= '0;
    end else begin
      sw_last_reg <= sw_sync;
      if (sw_sync != sw_last_reg) begin
        sw_cnt_reg <= '0;
      end else if (sw_cnt_reg == CNT_LAST) begin
        x_reg <= sw_sync;
      end else begin
        sw_cnt_reg <= sw_cnt_reg + CNT_ONE;
      end
    end
  end

  assign x = x_reg;
`else
  assign x = sw_sync;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner with DEB_CYCLES=4.
module tb_switch_conditioner;

  logic       clk;
  logic       nreset;
  logic [7:0] sw;
  logic       btn;
  logic [7:0] x;
  logic       Bstus;
  logic       Bpulse;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic       bstus;
    logic       bpulse;
    logic [7:0] x;
  } exp_t;

  exp_t sb_q[$];

  switch_conditioner #(
    .n          (8),
    .DEB_CYCLES (16'd4)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .sw     (sw),
    .btn    (btn),
    .x      (x),
    .Bstus  (Bstus),
    .Bpulse (Bpulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic eb, input logic ep, input logic [7:0] ex);
    exp_t e;
    e.tag    = tag;
    e.bstus  = eb;
    e.bpulse = ep;
    e.x      = ex;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    e = sb_q.pop_front();
    $display("txn %s: Bstus=%0b Bpulse=%0b x=%02h", e.tag, Bstus, Bpulse, x);
    check({e.tag, "_bstus"},  {31'd0, Bstus},  {31'd0, e.bstus});
    check({e.tag, "_bpulse"}, {31'd0, Bpulse}, {31'd0, e.bpulse});
    check({e.tag, "_x"},      {24'd0, x},      {24'd0, e.x});
  endtask

  // Drive inputs, record expectation, clock once, compare after the edge.
  task automatic cyc(input string tag, input logic b, input logic [7:0] s,
                     input logic eb, input logic ep, input logic [7:0] ex);
    btn = b;
    sw  = s;
    sb_push(tag, eb, ep, ex);
    @(posedge clk);
    #1;
    sb_compare();
  endtask

  task automatic press_seq(input string tag);
    for (int k = 1; k <= 5; k++) cyc($sformatf("%s_%0d", tag, k), 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    cyc($sformatf("%s_6", tag), 1'b1, 8'h00, 1'b1, 1'b1, 8'h00);
    for (int k = 7; k <= 8; k++) cyc($sformatf("%s_%0d", tag, k), 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic release_seq(input string tag);
    for (int k = 1; k <= 5; k++) cyc($sformatf("%s_%0d", tag, k), 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int k = 6; k <= 7; k++) cyc($sformatf("%s_%0d", tag, k), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       bpat [7];
    logic [7:0] swpat[10];
    logic [7:0] xexp [10];

    nreset = 1'b0;
    btn    = 1'b1;
    sw     = 8'hFF;

    // Reset holds outputs low before any clock edge and while clocking.
    #1;
    sb_push("rst_noclk", 1'b0, 1'b0, 8'h00);
    sb_compare();
    for (int k = 1; k <= 3; k++) cyc($sformatf("rst_clk_%0d", k), 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
    btn = 1'b0;
    sw  = 8'h00;
    #2 nreset = 1'b1;
    for (int k = 1; k <= 3; k++) cyc($sformatf("idle_%0d", k), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Clean press and release.
    press_seq("press");
    release_seq("release");

    // Bounce: synced samples 1,1,0,1,1,1,1 then held high.
    bpat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) cyc($sformatf("bounce_%0d", k + 1), bpat[k], 8'h00, 1'b0, 1'b0, 8'h00);
    cyc("bounce_8", 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    cyc("bounce_9", 1'b1, 8'h00, 1'b1, 1'b1, 8'h00);
    for (int k = 10; k <= 11; k++) cyc($sformatf("bounce_%0d", k), 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
    release_seq("bounce_rel");

    // Mid-count reset at cnt=2 abandons the count.
    for (int k = 1; k <= 4; k++) cyc($sformatf("mrst_pre_%0d", k), 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    nreset = 1'b0;
    #1;
    sb_push("mrst_async", 1'b0, 1'b0, 8'h00);
    sb_compare();
    #1 nreset = 1'b1;
    for (int k = 1; k <= 5; k++) cyc($sformatf("mrst_post_%0d", k), 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    cyc("mrst_post_6", 1'b1, 8'h00, 1'b1, 1'b1, 8'h00);
    cyc("mrst_post_7", 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset clears a high Bstus without a clock edge.
    btn    = 1'b0;
    nreset = 1'b0;
    #1;
    sb_push("arst_high", 1'b0, 1'b0, 8'h00);
    sb_compare();
    #1 nreset = 1'b1;
    for (int k = 1; k <= 6; k++) cyc($sformatf("arst_idle_%0d", k), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Switch bus: 00 -> A5, one-cycle flip to A4, then A5 held.
    swpat = '{8'hA5, 8'hA4, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
`ifdef SW_DEBOUNCE_EN
    xexp  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5};
`else
    xexp  = '{8'h00, 8'hA5, 8'hA4, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
`endif
    for (int k = 0; k < 10; k++) cyc($sformatf("sw_%0d", k + 1), 1'b0, swpat[k], 1'b0, 1'b0, xexp[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
